// File: rtl/ser_shift_param_if.sv
// Handshake/data bundle for the bit-serial shift/rotate unit.
// The master side drives the operation request and operand bits.
// The slave side (the unit itself) returns busy and the serial result.
interface ser_shift_param_if #(
  parameter int XLEN = 32
);
  localparam int SHW = $clog2(XLEN);

  logic           i_en;
  logic           i_start;
  logic [SHW-1:0] i_shamt;
  logic [2:0]     i_mode;
  logic           i_d;
  logic           o_busy;
  logic           o_q;
  logic           o_q_valid;
  logic           o_done;
  logic           o_err;

  modport master (
    output i_en, i_start, i_shamt, i_mode, i_d,
    input  o_busy, o_q, o_q_valid, o_done, o_err
  );

  modport slave (
    input  i_en, i_start, i_shamt, i_mode, i_d,
    output o_busy, o_q, o_q_valid, o_done, o_err
  );
endinterface

// File: rtl/ser_shift_param.sv
// Parametrised bit-serial shift/rotate unit (SLL/SRL/SRA/ROL/ROR).
// The operand is loaded LSB-first into a buffer, then each result bit k
// is picked straight out of the buffer by index arithmetic, so no
// physical shifting of the buffer is needed during EMIT.
module ser_shift_param #(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  ser_shift_param_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [SHW:0]   XLEN_X   = (SHW + 1)'(XLEN);

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b101;
  localparam logic [2:0] MODE_ROR = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            busy_r;
  logic [XLEN-1:0] buf_r;
  logic [SHW-1:0]  cnt_r;
  logic [SHW-1:0]  shamt_r;
  logic [2:0]      mode_r;

  logic            valid_s;
  logic            last_s;
  logic            q_s;
  logic            done_s;
  logic            err_s;

  // Reserved operation codes produce an all-zero result and flag o_err.
  function automatic logic mode_reserved(input logic [2:0] mode);
    logic rsv_v;
    case (mode)
      MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR: rsv_v = 1'b0;
      default:                                          rsv_v = 1'b1;
    endcase
    return rsv_v;
  endfunction

  // Result bit k selected from the loaded operand. Indices are formed one
  // bit wider than the counter so overflow past XLEN is visible; XLEN is a
  // power of two, so truncating to SHW bits is the modulo for rotates.
  function automatic logic result_bit(
    input logic [XLEN-1:0] b,
    input logic [SHW-1:0]  k,
    input logic [SHW-1:0]  s,
    input logic [2:0]      mode
  );
    logic [SHW:0] k_x;
    logic [SHW:0] s_x;
    logic [SHW:0] sum_x;
    logic [SHW:0] dif_x;
    logic         bit_v;
    k_x   = {1'b0, k};
    s_x   = {1'b0, s};
    sum_x = k_x + s_x;
    dif_x = k_x - s_x;
    bit_v = 1'b0;
    case (mode)
      MODE_SLL: begin
        if (k_x >= s_x) bit_v = b[dif_x[SHW-1:0]];
        else            bit_v = 1'b0;
      end
      MODE_SRL: begin
        if (sum_x < XLEN_X) bit_v = b[sum_x[SHW-1:0]];
        else                bit_v = 1'b0;
      end
      MODE_SRA: begin
        if (sum_x < XLEN_X) bit_v = b[sum_x[SHW-1:0]];
        else                bit_v = b[XLEN-1];
      end
      MODE_ROL: bit_v = b[dif_x[SHW-1:0]];
      MODE_ROR: bit_v = b[sum_x[SHW-1:0]];
      default:  bit_v = 1'b0;
    endcase
    return bit_v;
  endfunction

  // Next-state decode; LOAD and EMIT advance only on enabled cycles.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_start) state_s = ST_LOAD;
        else             state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (bus.i_en && last_s) state_s = ST_EMIT;
        else                    state_s = ST_LOAD;
      end
      ST_EMIT: begin
        if (bus.i_en && last_s) state_s = ST_IDLE;
        else                    state_s = ST_EMIT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and the registered busy flag that mirrors it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // Operand buffer, bit counter and captured operation parameters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      buf_r   <= {XLEN{1'b0}};
      cnt_r   <= {SHW{1'b0}};
      shamt_r <= {SHW{1'b0}};
      mode_r  <= 3'b000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_start) begin
            shamt_r <= bus.i_shamt;
            mode_r  <= bus.i_mode;
            cnt_r   <= {SHW{1'b0}};
          end
        end
        ST_LOAD: begin
          if (bus.i_en) begin
            buf_r <= {bus.i_d, buf_r[XLEN-1:1]};
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_EMIT: begin
          if (bus.i_en) begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          cnt_r <= {SHW{1'b0}};
        end
      endcase
    end
  end

  // Serial result and completion flags; gated by i_en so stalled EMIT
  // cycles present o_q_valid=0 and o_q=0.
  always_comb begin
    last_s  = (cnt_r == CNT_LAST);
    valid_s = (state_r == ST_EMIT) && bus.i_en;
    q_s     = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    if (valid_s) begin
      q_s    = result_bit(buf_r, cnt_r, shamt_r, mode_r);
      done_s = last_s;
      err_s  = last_s && mode_reserved(mode_r);
    end else begin
      q_s    = 1'b0;
      done_s = 1'b0;
      err_s  = 1'b0;
    end
  end

  assign bus.o_busy    = busy_r;
  assign bus.o_q       = q_s;
  assign bus.o_q_valid = valid_s;
  assign bus.o_done    = done_s;
  assign bus.o_err     = err_s;

endmodule

// File: tb/tb_ser_shift_param.sv
// Self-checking bench for ser_shift_param: directed table, stall/reset
// sequences and randomized operations against a word-level reference.
module tb_ser_shift_param;
  logic       clk;
  logic       rst;
  logic       en_s;
  logic       start_s;
  logic [5:0] shamt_s;
  logic [2:0] mode_s;
  logic       d_s;
  int         sel;
  int         total;
  int         bad;

  ser_shift_param_if #(.XLEN(32)) bus32 ();
  ser_shift_param_if #(.XLEN(64)) bus64 ();

  ser_shift_param #(.XLEN(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(bus32));
  ser_shift_param #(.XLEN(64)) dut64 (.i_clk(clk), .i_rst(rst), .bus(bus64));

  assign bus32.i_en    = (sel == 32) ? en_s    : 1'b0;
  assign bus32.i_start = (sel == 32) ? start_s : 1'b0;
  assign bus32.i_shamt = shamt_s[4:0];
  assign bus32.i_mode  = mode_s;
  assign bus32.i_d     = d_s;
  assign bus64.i_en    = (sel == 64) ? en_s    : 1'b0;
  assign bus64.i_start = (sel == 64) ? start_s : 1'b0;
  assign bus64.i_shamt = shamt_s;
  assign bus64.i_mode  = mode_s;
  assign bus64.i_d     = d_s;

  logic busy_o, q_o, valid_o, done_o, err_o;
  assign busy_o  = (sel == 32) ? bus32.o_busy    : bus64.o_busy;
  assign q_o     = (sel == 32) ? bus32.o_q       : bus64.o_q;
  assign valid_o = (sel == 32) ? bus32.o_q_valid : bus64.o_q_valid;
  assign done_o  = (sel == 32) ? bus32.o_done    : bus64.o_done;
  assign err_o   = (sel == 32) ? bus32.o_err     : bus64.o_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          w;
    logic [63:0] op;
    int          s;
    logic [2:0]  mode;
    int          en_kind;   // 0: always on, 1: random, 2: fixed stalls + stray start
    logic [63:0] exp;
    int          done_cyc;
    string       name;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit is_rsv(input logic [2:0] m);
    return !(m inside {3'b000, 3'b001, 3'b010, 3'b101, 3'b110});
  endfunction

  // Word-level reference: whole-operand shifts/rotates with SV operators.
  function automatic logic [63:0] ref_res(input logic [63:0] op_in, input int s,
                                          input logic [2:0] m, input int w);
    logic [63:0] mask;
    logic [63:0] op;
    logic [63:0] r;
    mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    op   = op_in & mask;
    case (m)
      3'b000: r = (op << s) & mask;
      3'b001: r = op >> s;
      3'b010: begin
        r = op >> s;
        if (op[w-1]) r = r | (~(mask >> s) & mask);
      end
      3'b101: r = ((op << s) | (op >> (w - s))) & mask;
      3'b110: r = ((op >> s) | (op << (w - s))) & mask;
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  // One full operation; cycle 0 is the start cycle.
  task automatic run_op(input int w, input logic [63:0] op, input int s,
                        input logic [2:0] m, input int en_kind,
                        input logic [63:0] exp, input int exp_done, input string name);
    int          cyc;
    int          li;
    int          ei;
    int          done_cyc;
    bit          fin;
    logic [63:0] res;
    cyc = 0; li = 0; ei = 0; done_cyc = -1; fin = 1'b0; res = 64'h0;
    sel = w;
    while (!fin && cyc < 600) begin
      @(negedge clk);
      if (cyc == 0) begin
        start_s = 1'b1;
        en_s    = (en_kind == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        shamt_s = 6'(s);
        mode_s  = m;
      end else begin
        if (ei >= w)           start_s = 1'b0;
        else if (en_kind == 1) start_s = ($urandom_range(0, 7) == 0);
        else                   start_s = (en_kind == 2 && cyc == 20);
        shamt_s = 6'($urandom);
        mode_s  = 3'($urandom);
        if (en_kind == 0)      en_s = 1'b1;
        else if (en_kind == 1) en_s = ($urandom_range(0, 3) != 0);
        else                   en_s = !(cyc inside {10, 11, 12, 45, 46, 47});
      end
      d_s = (li < w) ? op[li] : 1'($urandom);
      #1;
      if (cyc == 0) begin
        chk({name, " idle_busy"}, 64'(busy_o), 64'h0);
      end else if (ei < w) begin
        chk({name, " busy"}, 64'(busy_o), 64'h1);
        if (li < w) begin
          chk({name, " load_out"}, {61'h0, valid_o, q_o, done_o}, 64'h0);
          if (en_s) li++;
        end else begin
          chk({name, " valid"}, 64'(valid_o), 64'(en_s));
          if (en_s) begin
            res[ei] = q_o;
            chk({name, " done"}, 64'(done_o), 64'(ei == w - 1));
            chk({name, " err"}, 64'(err_o), 64'((ei == w - 1) && is_rsv(m)));
            if (ei == w - 1) done_cyc = cyc;
            ei++;
          end else begin
            chk({name, " stall_out"}, {61'h0, q_o, done_o, err_o}, 64'h0);
          end
        end
      end else begin
        chk({name, " after_done"}, {60'h0, busy_o, valid_o, done_o, err_o}, 64'h0);
        fin = 1'b1;
      end
      cyc++;
    end
    chk({name, " finished"}, 64'(fin), 64'h1);
    chk({name, " result"}, res, exp);
    if (exp_done >= 0) chk({name, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
  endtask

  initial begin
    total = 0; bad = 0; sel = 32;
    rst = 1'b1; en_s = 1'b0; start_s = 1'b0; shamt_s = 6'h0; mode_s = 3'h0; d_s = 1'b0;

    tbl[0] = '{32, 64'h8000_0001, 0, 3'b000, 0, 64'h8000_0001, 64, "sll0"};
    tbl[1] = '{32, 64'h8000_00F0, 4, 3'b010, 0, 64'hF800_000F, 64, "sra4"};
    tbl[2] = '{32, 64'h8000_00F0, 4, 3'b001, 0, 64'h0800_000F, 64, "srl4"};
    tbl[3] = '{32, 64'hFFFF_FFFF, 31, 3'b000, 0, 64'h8000_0000, 64, "sll31"};
    tbl[4] = '{32, 64'h1234_5678, 8, 3'b110, 0, 64'h7812_3456, 64, "ror8"};
    tbl[5] = '{32, 64'h0000_0001, 31, 3'b101, 0, 64'h8000_0000, 64, "rol31"};
    tbl[6] = '{32, 64'h1234_5678, 8, 3'b110, 2, 64'h7812_3456, 70, "ror8_stall"};
    tbl[7] = '{32, 64'hFFFF_FFFF, 5, 3'b011, 0, 64'h0, 64, "rsv011"};
    tbl[8] = '{64, 64'h8000_0000_0000_0000, 63, 3'b010, 0,
               64'hFFFF_FFFF_FFFF_FFFF, 128, "sra63_x64"};

    repeat (3) @(negedge clk);
    rst  = 1'b0;
    en_s = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = (i == 0) ? 32 : 64;
      #1;
      chk("reset_outputs", {59'h0, busy_o, q_o, valid_o, done_o, err_o}, 64'h0);
    end

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].w, tbl[i].op, tbl[i].s, tbl[i].mode, tbl[i].en_kind,
             tbl[i].exp, tbl[i].done_cyc, tbl[i].name);
    end

    // Reset in the middle of EMIT aborts with no completion pulse.
    begin
      bit saw_done;
      saw_done = 1'b0;
      sel = 32;
      for (int cyc = 0; cyc < 112; cyc++) begin
        @(negedge clk);
        start_s = (cyc == 0);
        en_s    = 1'b1;
        shamt_s = 6'd4;
        mode_s  = 3'b001;
        d_s     = 1'($urandom);
        rst     = (cyc == 40);
        #1;
        if (cyc == 40) chk("rst_busy_before", 64'(busy_o), 64'h1);
        if (cyc == 41) chk("rst_outputs_after", {60'h0, busy_o, valid_o, done_o, err_o}, 64'h0);
        if (cyc >= 41 && (done_o || busy_o)) saw_done = 1'b1;
      end
      chk("rst_no_done", 64'(saw_done), 64'h0);
    end

    for (int i = 0; i < 30; i++) begin
      int          w;
      int          s;
      logic [63:0] op;
      logic [2:0]  m;
      w  = ($urandom_range(0, 2) == 0) ? 64 : 32;
      op = {32'($urandom), 32'($urandom)};
      if (w == 32) op = op & 64'h0000_0000_FFFF_FFFF;
      s  = $urandom_range(0, w - 1);
      m  = 3'($urandom_range(0, 7));
      run_op(w, op, s, m, 1, ref_res(op, s, m, w), -1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ser_shift_param.md
# ser_shift_param

Parametrised bit-serial shift/rotate unit for the bit-serial RISC-V datapath, the successor to the fixed 32-bit serial shifter. It takes an XLEN-bit operand LSB-first, one bit per enabled cycle, then streams the result LSB-first, one bit per enabled cycle. Supported operations are SLL, SRL, SRA and the new ROL/ROR rotates. It sits beside the serial ALU and is paced by the same core-wide bit-enable used by the rest of the serial datapath.

## Interface
Parameters:
- XLEN, 32, operand width; legal values 32 or 64.
- SHW (localparam), $clog2(XLEN), shift-amount width.

Ports:
- i_clk  in  1  core clock; everything is rising-edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  bit-enable; LOAD/EMIT progress only on cycles with i_en=1.
- i_start  in  1  start request; accepted only in IDLE.
- i_shamt  in  SHW  shift amount, captured on accepted start.
- i_mode  in  3  operation, captured on accepted start; 000 SLL, 001 SRL, 010 SRA, 101 ROL, 110 ROR; other codes reserved.
- i_d  in  1  serial operand bit, LSB first, sampled in LOAD when i_en=1.
- o_busy  out  1  high in LOAD and EMIT.
- o_q  out  1  serial result bit, LSB first; 0 whenever o_q_valid=0.
- o_q_valid  out  1  o_q carries a result bit this cycle.
- o_done  out  1  one-cycle pulse with the last result bit.
- o_err  out  1  pulses together with o_done when the captured mode was reserved.

## Operation
- States are IDLE, LOAD and EMIT. Internal state is an XLEN-bit buffer, an SHW-bit bit counter, and the captured shamt and mode.
- IDLE→LOAD when i_start=1. The start is accepted regardless of i_en. Shamt and mode are captured, and the counter is cleared. i_start outside IDLE is ignored; this includes the o_done cycle.
- LOAD: on each i_en=1 cycle the buffer takes i_d, as buf <= {i_d, buf[XLEN-1:1]}, and the counter increments. When the XLEN-th bit is sampled (counter wraps to 0), go to EMIT.
- EMIT: o_q_valid = i_en. For result bit index k (counter value), with b = buffer (operand bit j = b[j]) and s = shamt:
  - SLL: k≥s ? b[k−s] : 0.
  - SRL: k+s<XLEN ? b[k+s] : 0.
  - SRA: k+s<XLEN ? b[k+s] : b[XLEN−1].
  - ROL: b[(k−s) mod XLEN].
  - ROR: b[(k+s) mod XLEN].
  - Reserved mode: the result is 0.
- The counter increments on each i_en=1 EMIT cycle. On k=XLEN−1 with i_en=1, assert o_done (and o_err if the mode is reserved), then go to IDLE.
- shamt=0 gives the identity for every legal mode. shamt spans 0..XLEN−1 only; there is no shift by XLEN.
- Index arithmetic is done at SHW+1 bits; there are no out-of-range buffer reads.

## Timing
- Reset: on i_rst=1 at an edge, the state becomes IDLE and the counter, buffer, shamt and mode clear to 0. o_busy, o_q, o_q_valid, o_done and o_err are all 0 from the following cycle.
- Reset mid-operation aborts the operation with no o_done.
- o_busy is registered from the state. o_q, o_q_valid, o_done and o_err are combinational from registered state and i_en; they do not depend on i_d.
- With i_en held high and the start at cycle 0:
  - LOAD samples operand bits 0..XLEN−1 at cycles 1..XLEN.
  - EMIT drives result bits 0..XLEN−1 at cycles XLEN+1..2·XLEN.
  - o_done is at cycle 2·XLEN.
  - IDLE is at cycle 2·XLEN+1, which is the earliest next start.
- Each i_en=0 cycle in LOAD or EMIT freezes all state and delays completion by one cycle. During such a cycle in EMIT, o_q_valid=0 and o_q=0.
- Throughput is one operation per 2·XLEN+1 enabled cycles.

## Test plan
- XLEN=32, SLL, shamt 0, operand 0x8000_0001, i_en=1 → result 0x8000_0001; o_done at cycle 64; o_busy low at cycle 65.
- SRA shamt 4 on 0x8000_00F0 → 0xF800_000F. SRL shamt 4 on the same operand → 0x0800_000F. SLL shamt 31 on 0xFFFF_FFFF → 0x8000_0000.
- ROR shamt 8 on 0x1234_5678 → 0x7812_3456. ROL shamt 31 on 0x0000_0001 → 0x8000_0000.
- i_en low for 3 cycles in LOAD and 3 cycles in EMIT on ROR 8 of 0x1234_5678 → same result; o_done at cycle 70; o_q_valid=0 on the stalled cycles. An i_start pulse at cycle 20 is ignored.
- Reset asserted at cycle 40 of SRL → o_busy=0 at cycle 41 and no o_done. Mode 011 with operand 0xFFFF_FFFF → all 32 result bits 0, with o_err=1 only with o_done.
- XLEN=64, SRA shamt 63 on 0x8000_0000_0000_0000 → 0xFFFF_FFFF_FFFF_FFFF; o_done at cycle 128.
